// File: rtl/tug_field.sv
// Tug of War playfield: one-hot rope position, round-win detection with a
// fixed winner hold, per-player scores and match-over freeze.
module tug_field #(
   parameter int NUM_LIGHTS  = 9,
   parameter int HOLD_CYCLES = 4,
   parameter int MAX_SCORE   = 7
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  L,
   input  logic                  R,
   output logic [NUM_LIGHTS-1:0] lights,
   output logic [1:0]            winner,
   output logic [2:0]            score_l,
   output logic [2:0]            score_r,
   output logic                  match_over
);

   localparam int POS_W  = $clog2(NUM_LIGHTS);
   localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   localparam logic [POS_W-1:0]  CENTRE    = POS_W'((NUM_LIGHTS - 1) / 2);
   localparam logic [POS_W-1:0]  LAST      = POS_W'(NUM_LIGHTS - 1);
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [2:0]        MAX_S     = 3'(MAX_SCORE);

   localparam logic [1:0] ST_PLAY = 2'b00;
   localparam logic [1:0] ST_WIN  = 2'b01;
   localparam logic [1:0] ST_OVER = 2'b10;

   localparam logic [1:0] WIN_NONE  = 2'b00;
   localparam logic [1:0] WIN_LEFT  = 2'b01;
   localparam logic [1:0] WIN_RIGHT = 2'b10;

   function automatic logic [2:0] sat_inc(input logic [2:0] s);
      return (s == 3'd7) ? s : s + 3'd1;
   endfunction

   function automatic logic [NUM_LIGHTS-1:0] one_hot(input logic [POS_W-1:0] p);
      return {{(NUM_LIGHTS-1){1'b0}}, 1'b1} << p;
   endfunction

   logic [1:0]            state_q, state_d;
   logic [POS_W-1:0]      pos_q, pos_d;
   logic [HOLD_W-1:0]     hold_q, hold_d;
   logic [NUM_LIGHTS-1:0] lights_q, lights_d;
   logic [1:0]            winner_q, winner_d;
   logic [2:0]            score_l_q, score_l_d;
   logic [2:0]            score_r_q, score_r_d;
   logic                  match_over_q, match_over_d;

   logic                  mv_l, mv_r;
   logic [2:0]            win_score;

   assign mv_l = L & ~R;
   assign mv_r = R & ~L;

   always_comb begin
      state_d      = state_q;
      pos_d        = pos_q;
      hold_d       = hold_q;
      lights_d     = lights_q;
      winner_d     = winner_q;
      score_l_d    = score_l_q;
      score_r_d    = score_r_q;
      match_over_d = match_over_q;
      win_score    = (winner_q == WIN_LEFT) ? score_l_q : score_r_q;

      case (state_q)
         ST_PLAY: begin
            // Simultaneous presses cancel: neither mv_l nor mv_r is set.
            if (mv_l) begin
               if (pos_q == LAST) begin
                  state_d   = ST_WIN;
                  winner_d  = WIN_LEFT;
                  lights_d  = '0;
                  score_l_d = sat_inc(score_l_q);
                  hold_d    = HOLD_LOAD;
               end else begin
                  pos_d    = pos_q + POS_W'(1);
                  lights_d = one_hot(pos_q + POS_W'(1));
               end
            end else if (mv_r) begin
               if (pos_q == '0) begin
                  state_d   = ST_WIN;
                  winner_d  = WIN_RIGHT;
                  lights_d  = '0;
                  score_r_d = sat_inc(score_r_q);
                  hold_d    = HOLD_LOAD;
               end else begin
                  pos_d    = pos_q - POS_W'(1);
                  lights_d = one_hot(pos_q - POS_W'(1));
               end
            end
         end
         ST_WIN: begin
            // Score was already bumped on entry, so compare the stored value.
            if (hold_q == '0) begin
               if (win_score == MAX_S) begin
                  state_d      = ST_OVER;
                  match_over_d = 1'b1;
               end else begin
                  state_d  = ST_PLAY;
                  pos_d    = CENTRE;
                  lights_d = one_hot(CENTRE);
                  winner_d = WIN_NONE;
               end
            end else begin
               hold_d = hold_q - HOLD_W'(1);
            end
         end
         ST_OVER: begin
         end
         default: begin
            state_d      = ST_PLAY;
            pos_d        = CENTRE;
            hold_d       = '0;
            lights_d     = one_hot(CENTRE);
            winner_d     = WIN_NONE;
            match_over_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q      <= ST_PLAY;
         pos_q        <= CENTRE;
         hold_q       <= '0;
         lights_q     <= one_hot(CENTRE);
         winner_q     <= WIN_NONE;
         score_l_q    <= 3'd0;
         score_r_q    <= 3'd0;
         match_over_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pos_q        <= pos_d;
         hold_q       <= hold_d;
         lights_q     <= lights_d;
         winner_q     <= winner_d;
         score_l_q    <= score_l_d;
         score_r_q    <= score_r_d;
         match_over_q <= match_over_d;
      end
   end

   assign lights     = lights_q;
   assign winner     = winner_q;
   assign score_l    = score_l_q;
   assign score_r    = score_r_q;
   assign match_over = match_over_q;

endmodule

// File: tb/tb_tug_field.sv
// Directed bench for tug_field at default parameters; expected values are
// hand-derived constants.
module tb_tug_field;

   logic       clk;
   logic       rst;
   logic       l_in;
   logic       r_in;
   logic [8:0] lights;
   logic [1:0] winner;
   logic [2:0] score_l;
   logic [2:0] score_r;
   logic       match_over;

   int checks = 0;
   int errors = 0;

   tug_field #(
      .NUM_LIGHTS (9),
      .HOLD_CYCLES(4),
      .MAX_SCORE  (7)
   ) dut (
      .Clock     (clk),
      .Reset     (rst),
      .L         (l_in),
      .R         (r_in),
      .lights    (lights),
      .winner    (winner),
      .score_l   (score_l),
      .score_r   (score_r),
      .match_over(match_over)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic press_l();
      l_in = 1'b1;
      step();
      l_in = 1'b0;
   endtask

   task automatic press_r();
      r_in = 1'b1;
      step();
      r_in = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      rst  = 1'b1;
      l_in = 1'b0;
      r_in = 1'b0;
      do_reset();

      // Reset state after idle.
      repeat (5) step();
      chk("rst_lights", 32'(lights), 32'h010);
      chk("rst_winner", 32'(winner), 32'd0);
      chk("rst_score_l", 32'(score_l), 32'd0);
      chk("rst_score_r", 32'(score_r), 32'd0);
      chk("rst_match_over", 32'(match_over), 32'd0);

      // Left walks the rope off the left end.
      press_l(); chk("l1_lights", 32'(lights), 32'h020); step();
      press_l(); chk("l2_lights", 32'(lights), 32'h040); step();
      press_l(); chk("l3_lights", 32'(lights), 32'h080); step();
      press_l(); chk("l4_lights", 32'(lights), 32'h100); step();
      press_l();
      chk("lwin_lights", 32'(lights), 32'h000);
      chk("lwin_winner", 32'(winner), 32'd1);
      chk("lwin_score_l", 32'(score_l), 32'd1);
      step(); step(); step();
      chk("lhold3_lights", 32'(lights), 32'h000);
      chk("lhold3_winner", 32'(winner), 32'd1);
      step();
      chk("lhold4_lights", 32'(lights), 32'h010);
      chk("lhold4_winner", 32'(winner), 32'd0);

      // Tie cancels, then a single right step.
      l_in = 1'b1; r_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("tie_lights", 32'(lights), 32'h010);
      end
      l_in = 1'b0; r_in = 1'b0;
      press_r();
      chk("tie_r_lights", 32'(lights), 32'h008);
      press_l();
      chk("back_centre", 32'(lights), 32'h010);

      // Right wins seven rounds and ends the match.
      for (int rnd = 1; rnd <= 7; rnd++) begin
         for (int p = 0; p < 5; p++) begin
            press_r();
            step();
         end
         // Last step above was the first hold cycle; three more remain.
         chk("rwin_score_r", 32'(score_r), 32'(rnd));
         chk("rwin_winner", 32'(winner), 32'd2);
         step(); step();
         chk("rhold_match_over", 32'(match_over), 32'd0);
         step();
         if (rnd < 7) begin
            chk("rnext_lights", 32'(lights), 32'h010);
            chk("rnext_winner", 32'(winner), 32'd0);
         end
      end
      chk("over_match_over", 32'(match_over), 32'd1);
      chk("over_winner", 32'(winner), 32'd2);
      chk("over_lights", 32'(lights), 32'h000);
      for (int i = 0; i < 10; i++) begin
         l_in = i[0];
         r_in = ~i[0];
         step();
      end
      l_in = 1'b0; r_in = 1'b0;
      step();
      chk("frozen_lights", 32'(lights), 32'h000);
      chk("frozen_winner", 32'(winner), 32'd2);
      chk("frozen_score_r", 32'(score_r), 32'd7);
      chk("frozen_score_l", 32'(score_l), 32'd1);
      chk("frozen_match_over", 32'(match_over), 32'd1);

      // Reset in the middle of a win hold.
      do_reset();
      chk("rst2_lights", 32'(lights), 32'h010);
      for (int p = 0; p < 5; p++) press_l();
      chk("hold_rst_pre_score_l", 32'(score_l), 32'd1);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("hold_rst_lights", 32'(lights), 32'h010);
      chk("hold_rst_winner", 32'(winner), 32'd0);
      chk("hold_rst_score_l", 32'(score_l), 32'd0);
      chk("hold_rst_match_over", 32'(match_over), 32'd0);

      // Presses during a hold are ignored.
      for (int p = 0; p < 5; p++) press_l();
      chk("ign_win_score_l", 32'(score_l), 32'd1);
      l_in = 1'b1;
      step(); step();
      l_in = 1'b0;
      step();
      chk("ign_hold_lights", 32'(lights), 32'h000);
      chk("ign_hold_score_l", 32'(score_l), 32'd1);
      chk("ign_hold_winner", 32'(winner), 32'd1);
      step();
      chk("ign_next_lights", 32'(lights), 32'h010);
      chk("ign_next_winner", 32'(winner), 32'd0);
      press_l();
      chk("ign_first_step", 32'(lights), 32'h020);
      chk("ign_final_score_l", 32'(score_l), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
